// File: rtl/tdm_mux_pkg.sv
// Shared constants and types for the 32:1 time-division multiplexer.
package tdm_mux_pkg;

  localparam int unsigned CHANNELS  = 32;
  localparam int unsigned SEL_WIDTH = $clog2(CHANNELS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage : tdm_mux_pkg

// File: rtl/lowest_set_bit_32.sv
// Combinational priority encoder: index of the lowest set bit, plus a flag
// telling whether at most one bit is set (last-beat detection).
module lowest_set_bit_32
  import tdm_mux_pkg::*;
(
  input  logic [CHANNELS-1:0]  vec_i,
  output logic [SEL_WIDTH-1:0] idx_o,
  output logic                 one_hot_or_zero_o
);

  // Scan downward so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx_o = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = SEL_WIDTH'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves zero only when at most one bit was set.
  assign one_hot_or_zero_o = ((vec_i & (vec_i - CHANNELS'(1))) == '0);

endmodule : lowest_set_bit_32

// File: rtl/tdm_mux_32_1.sv
// 32-channel TDM sender: captures a masked parallel frame and streams the
// selected channels as (index, bit) beats in ascending index order.
module tdm_mux_32_1
  import tdm_mux_pkg::*;
(
  input  logic                 Clock_In,
  input  logic                 Reset_n_In,
  input  logic                 Enable_In,
  input  logic                 Frame_Valid_In,
  output logic                 Frame_Ready_Out,
  input  logic [CHANNELS-1:0]  Data_In,
  input  logic [CHANNELS-1:0]  Channel_Mask_In,
  output logic                 Serial_Valid_Out,
  input  logic                 Serial_Ready_In,
  output logic                 Serial_Data_Out,
  output logic [SEL_WIDTH-1:0] Select_Out,
  output logic                 Frame_Start_Out,
  output logic                 Frame_End_Out,
  output logic                 Busy_Out
);

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] data_q, data_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CHANNELS-1:0] rem_q,  rem_d;

  logic [SEL_WIDTH-1:0] cur_idx;
  logic                 last_beat;
  logic                 in_send;

  lowest_set_bit_32 u_lsb (
    .vec_i             (rem_q),
    .idx_o             (cur_idx),
    .one_hot_or_zero_o (last_beat)
  );

  assign in_send = (state_q == SEND);

  // State and capture registers; reset discards any frame in flight.
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q <= IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic: accept frames in IDLE, retire one channel per beat in SEND.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        // An all-zero mask is consumed but produces no beats.
        if (Enable_In && Frame_Valid_In && (Channel_Mask_In != '0)) begin
          data_d  = Data_In;
          mask_d  = Channel_Mask_In;
          rem_d   = Channel_Mask_In;
          state_d = SEND;
        end
      end
      SEND: begin
        if (Serial_Ready_In) begin
          rem_d = rem_q & ~(CHANNELS'(1) << cur_idx);
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come from registered state only, except ready which also follows Enable_In.
  always_comb begin
    Frame_Ready_Out  = 1'b0;
    Serial_Valid_Out = 1'b0;
    Serial_Data_Out  = 1'b0;
    Select_Out       = '0;
    Frame_Start_Out  = 1'b0;
    Frame_End_Out    = 1'b0;
    Busy_Out         = in_send;
    if (in_send) begin
      Serial_Valid_Out = 1'b1;
      Serial_Data_Out  = data_q[cur_idx];
      Select_Out       = cur_idx;
      Frame_Start_Out  = (rem_q == mask_q);
      Frame_End_Out    = last_beat;
    end else begin
      Frame_Ready_Out  = Enable_In;
    end
  end

endmodule : tdm_mux_32_1

// File: tb/tb_tdm_mux_32_1.sv
// Scoreboard bench for tdm_mux_32_1: each accepted frame pushes its expected
// beats; a negedge monitor pops and compares every beat the DUT hands over.
module tb_tdm_mux_32_1;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        fv;
  logic        fready;
  logic [31:0] din;
  logic [31:0] mask;
  logic        svalid;
  logic        sready;
  logic        sdata;
  logic [4:0]  sel;
  logic        fstart;
  logic        fend;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Beat encoding: {sel[4:0], data, start, end}
  logic [7:0] sb_q[$];

  logic       stall_seen;
  logic [7:0] stall_beat;
  logic       end_seen;

  tdm_mux_32_1 dut (
    .Clock_In         (clk),
    .Reset_n_In       (rst_n),
    .Enable_In        (en),
    .Frame_Valid_In   (fv),
    .Frame_Ready_Out  (fready),
    .Data_In          (din),
    .Channel_Mask_In  (mask),
    .Serial_Valid_Out (svalid),
    .Serial_Ready_In  (sready),
    .Serial_Data_Out  (sdata),
    .Select_Out       (sel),
    .Frame_Start_Out  (fstart),
    .Frame_End_Out    (fend),
    .Busy_Out         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beats for a frame: ascending set mask bits, first flagged start, last flagged end.
  task automatic push_model(input logic [31:0] d, input logic [31:0] m);
    int  hi;
    logic first;
    hi    = -1;
    first = 1'b1;
    for (int i = 0; i < 32; i++) if (m[i]) hi = i;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        sb_q.push_back({5'(i), d[i], first, (i == hi)});
        first = 1'b0;
      end
    end
  endtask

  // Offer one frame while the DUT is idle; it must be taken on the next edge.
  task automatic send_frame(input logic [31:0] d, input logic [31:0] m);
    @(posedge clk);
    #1;
    din  = d;
    mask = m;
    fv   = 1'b1;
    @(negedge clk);
    chk("frame_ready_idle", 32'(fready), 32'd1);
    @(posedge clk);
    #1;
    fv = 1'b0;
    push_model(d, m);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  // Monitor: compares handshaken beats, idle zeros, stall stability and ready gap.
  always @(negedge clk) begin
    logic [7:0] cur;
    logic [7:0] exp;
    if (!rst_n) begin
      stall_seen = 1'b0;
      end_seen   = 1'b0;
    end else begin
      cur = {sel, sdata, fstart, fend};
      chk("valid_vs_sb", 32'(svalid), 32'(sb_q.size() != 0));
      chk("busy_vs_sb", 32'(busy), 32'(sb_q.size() != 0));
      if (stall_seen) chk("stall_hold", 32'({svalid, cur}), 32'({1'b1, stall_beat}));
      if (end_seen) chk("ready_after_end", 32'(fready), 32'(en));
      stall_seen = 1'b0;
      end_seen   = 1'b0;
      if (!svalid) begin
        chk("idle_outs_zero", 32'(cur), 32'd0);
      end else if (!sready) begin
        stall_seen = 1'b1;
        stall_beat = cur;
      end else if (sb_q.size() == 0) begin
        chk("unexpected_beat", 32'(cur), 32'hFFFF);
      end else begin
        exp = sb_q.pop_front();
        chk("beat", 32'(cur), 32'(exp));
        if (exp[0]) begin
          chk("ready_low_at_end", 32'(fready), 32'd0);
          end_seen = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    fv     = 1'b0;
    din    = '0;
    mask   = '0;
    sready = 1'b1;

    // Reset values
    #12;
    chk("rst_outs", 32'({svalid, sdata, sel, fstart, fend, busy}), 32'd0);
    chk("rst_ready_en1", 32'(fready), 32'd1);
    en = 1'b0;
    #1;
    chk("rst_ready_en0", 32'(fready), 32'd0);
    en = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Full mask, streaming
    send_frame(32'hA5A5_F00F, 32'hFFFF_FFFF);
    wait_drain();

    // Sparse mask with wide gap
    send_frame(32'h8000_0001, 32'h8000_0011);
    wait_drain();

    // Single-channel frame
    send_frame(32'h0000_0400, 32'h0000_0400);
    wait_drain();

    // Empty mask: consumed and dropped
    send_frame(32'hFFFF_FFFF, 32'h0000_0000);
    @(negedge clk);
    chk("zero_mask_ready", 32'(fready), 32'd1);
    chk("zero_mask_busy", 32'(busy), 32'd0);

    // Back-pressure on beat 2, with frame offers during SEND
    send_frame(32'h1234_5678, 32'hFFFF_FFFF);
    @(posedge clk);
    @(posedge clk);
    #1;
    sready = 1'b0;
    fv     = 1'b1;
    din    = 32'hFFFF_FFFF;
    mask   = 32'h0000_0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_sel", 32'(sel), 32'd2);
      chk("stall_ready", 32'(fready), 32'd0);
      @(posedge clk);
      #1;
    end
    sready = 1'b1;
    fv     = 1'b0;
    wait_drain();

    // Reset in the middle of a frame
    send_frame(32'hDEAD_BEEF, 32'hFFFF_FFFF);
    repeat (7) @(posedge clk);
    #2;
    chk("pre_rst_sel", 32'(sel), 32'd7);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("mid_rst_outs", 32'({svalid, sdata, sel, fstart, fend, busy}), 32'd0);
    chk("mid_rst_ready", 32'(fready), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(fready), 32'd1);
    send_frame(32'h0000_0100, 32'h0000_0300);
    wait_drain();

    // Enable low blocks acceptance
    @(posedge clk);
    #1;
    en   = 1'b0;
    fv   = 1'b1;
    din  = 32'hFFFF_FFFF;
    mask = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("en0_ready", 32'(fready), 32'd0);
    end
    @(posedge clk);
    #1;
    fv = 1'b0;
    en = 1'b1;

    // Enable dropped mid-frame: frame still completes
    send_frame(32'h0F0F_0F0F, 32'h0000_FF00);
    repeat (3) @(posedge clk);
    #1;
    en = 1'b0;
    wait_drain();
    @(negedge clk);
    chk("en_drop_ready", 32'(fready), 32'd0);
    en = 1'b1;
    @(negedge clk);
    chk("en_restore_ready", 32'(fready), 32'd1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_tdm_mux_32_1

// File: doc/tdm_mux_32_1.md
# tdm_mux_32_1

Time-division multiplexer that gathers a 32-channel parallel snapshot and emits it as a stream of (channel index, data bit) beats. It is the sending end for the team's 1:32 demultiplexers: Select_Out/Serial_Data_Out drive a DEMUX_1_32 select/data pair directly. A per-frame channel mask skips unused channels. A valid/ready handshake on both sides gives back-pressure.

## Interface
- CHANNELS, 32, number of input channels (fixed at 32 for this block)
- SEL_WIDTH, 5, index width = clog2(CHANNELS)

- Clock_In  input  1  single clock, all state on rising edge
- Reset_n_In  input  1  asynchronous, active-low reset
- Enable_In  input  1  gates frame acceptance only
- Frame_Valid_In  input  1  parallel frame offered
- Frame_Ready_Out  output  1  frame accepted when Valid and Ready are both high
- Data_In  input  32  channel data, bit i = channel i
- Channel_Mask_In  input  32  bit i high = emit channel i
- Serial_Valid_Out  output  1  beat valid
- Serial_Ready_In  input  1  downstream accepts beat
- Serial_Data_Out  output  1  data bit of current channel
- Select_Out  output  5  index of current channel
- Frame_Start_Out  output  1  current beat is first of frame
- Frame_End_Out  output  1  current beat is last of frame
- Busy_Out  output  1  frame in progress

## Operation
- States: IDLE, SEND.
- IDLE:
  - Frame_Ready_Out = Enable_In.
  - On frame handshake with mask != 0: capture Data_In into data_q, capture Channel_Mask_In into mask_q and rem_q, go to SEND.
  - On frame handshake with mask == 0: frame is consumed and dropped; stay IDLE; no beats are emitted.
- SEND:
  - Frame_Ready_Out = 0.
  - cur = index of the lowest set bit of rem_q.
  - Serial_Valid_Out = 1, Select_Out = cur, Serial_Data_Out = data_q[cur].
  - Frame_Start_Out = (rem_q == mask_q).
  - Frame_End_Out = (rem_q has exactly one bit set).
  - On beat handshake: clear rem_q[cur]. If this is the last beat, go to IDLE.
  - Serial_Ready_In low: all outputs are held stable. A valid beat is never retracted or changed.
- Channels are emitted in strictly ascending index order. There is no wrap-around within a frame.
- Enable_In deasserting in SEND does not stall or abort the frame; the frame completes.
- A single-channel frame asserts Frame_Start_Out and Frame_End_Out on the same beat.
- When Serial_Valid_Out = 0: Serial_Data_Out, Select_Out, Frame_Start_Out and Frame_End_Out are all 0.
- Busy_Out = (state == SEND).

## Timing
- Reset (async assert, sync-safe release):
  - State goes to IDLE; data_q, mask_q, rem_q go to 0.
  - Serial_Valid_Out, Serial_Data_Out, Select_Out, Frame_Start_Out, Frame_End_Out and Busy_Out are all 0.
  - Frame_Ready_Out follows Enable_In.
- Reset asserted mid-frame: the frame is discarded immediately; the outputs take their reset values in the same cycle (asynchronous).
- Latency: frame accepted at edge N gives the first beat valid after edge N, i.e. in cycle N+1.
- Throughput: one beat per cycle while Serial_Ready_In is held high.
- A K-channel frame occupies SEND for at least K cycles.
- Frame_Ready_Out is low in the cycle of the last beat. The next frame can be accepted in the following cycle at the earliest, giving a minimum 1-cycle gap between frames.
- No combinational path from Serial_Ready_In or any data/mask input to any output. Frame_Ready_Out depends combinationally on Enable_In and state only.

## Structure
- Package tdm_mux_pkg:
  - CHANNELS, SEL_WIDTH constants.
  - state enum {IDLE, SEND}.
- Sub-module lowest_set_bit_32: combinational priority encoder.
  - Inputs: 32-bit vector.
  - Outputs: 5-bit index and a one_hot_or_zero flag, used for Frame_End_Out detection.
- The top level holds the FSM, the capture registers and the output mux.

## Test plan
- Full mask, Data_In=32'hA5A5_F00F, Serial_Ready_In=1 -> 32 consecutive beats with Select_Out 0..31 and Serial_Data_Out = bit i; Start on beat 0, End on beat 31; Frame_Ready_Out high again 1 cycle after End.
- Mask=32'h8000_0011, Data_In=32'h8000_0001 -> 3 beats: (0,1,Start), (4,0), (31,1,End); then Busy_Out=0.
- Mask=32'h0000_0400 -> one beat, Select_Out=10, Start and End both high. Mask=0 -> frame accepted, no Serial_Valid_Out, Frame_Ready_Out stays high.
- Serial_Ready_In held low 5 cycles on beat 2 of a full-mask frame -> Select_Out=2 and data stable for all 5 cycles; beats resume in order with none lost or duplicated; Frame_Valid_In pulses during SEND are not accepted.
- Reset_n_In pulsed low at beat 7 of a full-mask frame -> all outputs 0 immediately. After release: IDLE, Frame_Ready_Out = Enable_In, and the next frame starts at Select_Out = lowest mask bit.
- Enable_In=0 with Frame_Valid_In=1 -> no acceptance. Enable_In dropped mid-frame -> the frame completes all beats.
